ripple_adder_8bit: RTL and testbench

RIPPLE_ADDER_8BIT -- requirements
Module: ripple_adder_8bit

---
 rtl/ripple_adder_8bit.sv | 50 +++++
 tb/tb_ripple_adder_8bit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/ripple_adder_8bit.sv
// 8-bit ripple-carry adder built from cascaded full-adder stages.
// Combinational sum/carry_out, plus registered sum, carry, signed-overflow and zero flags.
module ripple_adder_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       carry_out,
  output logic [7:0] sum_q,
  output logic       carry_out_q,
  output logic       overflow_q,
  output logic       zero_q
);

  localparam int unsigned W = 8;

  logic [W:0] c;
  logic       overflow;
  logic       zero;

  assign c[0] = carry_in;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < W; i++) begin : g_stage
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign carry_out = c[W];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow  = c[W-1] ^ c[W];
  assign zero      = (sum == W'(0));

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= W'(0);
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      sum_q       <= sum;
      carry_out_q <= carry_out;
      overflow_q  <= overflow;
      zero_q      <= zero;
    end
  end

endmodule

// File: tb/tb_ripple_adder_8bit.sv
// Self-checking bench for ripple_adder_8bit: directed vectors, reset sequences,
// and random vectors checked against an arithmetic reference model.
module tb_ripple_adder_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       carry_in;
  logic [7:0] sum;
  logic       carry_out;
  logic [7:0] sum_q;
  logic       carry_out_q;
  logic       overflow_q;
  logic       zero_q;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ripple_adder_8bit dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .carry_in    (carry_in),
    .sum         (sum),
    .carry_out   (carry_out),
    .sum_q       (sum_q),
    .carry_out_q (carry_out_q),
    .overflow_q  (overflow_q),
    .zero_q      (zero_q)
  );

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: integer addition, overflow from operand/result sign rule.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic mc,
                       output logic [7:0] s, output logic co, output logic ov,
                       output logic z);
    int unsigned t;
    t  = int'(ma) + int'(mb) + int'(mc);
    s  = 8'(t % 256);
    co = (t >= 256);
    ov = (ma[7] == mb[7]) && (s[7] != ma[7]);
    z  = (s == 8'h00);
  endtask

  task automatic run_vec(input string name, input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input logic [7:0] es, input logic eco,
                         input logic eov, input logic ez);
    @(negedge clk);
    a = va; b = vb; carry_in = vc;
    #1;
    check({name, ".sum"}, {1'b0, sum}, {1'b0, es});
    check({name, ".carry_out"}, {8'h0, carry_out}, {8'h0, eco});
    @(posedge clk);
    #1;
    check({name, ".sum_q"}, {1'b0, sum_q}, {1'b0, es});
    check({name, ".carry_out_q"}, {8'h0, carry_out_q}, {8'h0, eco});
    check({name, ".overflow_q"}, {8'h0, overflow_q}, {8'h0, eov});
    check({name, ".zero_q"}, {8'h0, zero_q}, {8'h0, ez});
  endtask

  initial begin
    logic [7:0] ms;
    logic       mco, mov, mz;

    vt[0] = '{"zero_minus_zero", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[1] = '{"ff_minus_one",    8'hFF, 8'hFE, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0};
    vt[2] = '{"zero_minus_one",  8'h00, 8'hFE, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vt[3] = '{"x55_minus_xaa",   8'h55, 8'h55, 1'b1, 8'hAB, 1'b0, 1'b1, 1'b0};
    vt[4] = '{"x80_minus_x80",   8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

    // Reset state; inputs chosen so an unreset load would set zero_q.
    rst = 1'b1; a = 8'h00; b = 8'h00; carry_in = 1'b0;
    @(posedge clk);
    #1;
    check("reset.sum_q", {1'b0, sum_q}, 9'h000);
    check("reset.carry_out_q", {8'h0, carry_out_q}, 9'h000);
    check("reset.overflow_q", {8'h0, overflow_q}, 9'h000);
    check("reset.zero_q", {8'h0, zero_q}, 9'h000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_vec(vt[i].name, vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].co, vt[i].ov, vt[i].z);

    // Load 0xFF+0x01 then reset: registers clear, combinational result stays valid.
    @(negedge clk);
    a = 8'hFF; b = 8'h01; carry_in = 1'b0;
    @(posedge clk);
    #1;
    check("wrap.zero_q", {8'h0, zero_q}, 9'h001);
    check("wrap.carry_out_q", {8'h0, carry_out_q}, 9'h001);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst.sum_q", {1'b0, sum_q}, 9'h000);
    check("midrst.carry_out_q", {8'h0, carry_out_q}, 9'h000);
    check("midrst.overflow_q", {8'h0, overflow_q}, 9'h000);
    check("midrst.zero_q", {8'h0, zero_q}, 9'h000);
    check("midrst.sum", {1'b0, sum}, 9'h000);
    check("midrst.carry_out", {8'h0, carry_out}, 9'h001);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("postrst.zero_q", {8'h0, zero_q}, 9'h001);
    check("postrst.carry_out_q", {8'h0, carry_out_q}, 9'h001);

    // Overflow into reset: a positive-overflow result must not survive reset.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; carry_in = 1'b0; rst = 1'b1;
    #1;
    check("rstcomb.sum", {1'b0, sum}, 9'h080);
    @(posedge clk);
    #1;
    check("rstprio.overflow_q", {8'h0, overflow_q}, 9'h000);
    check("rstprio.sum_q", {1'b0, sum_q}, 9'h000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ovload.overflow_q", {8'h0, overflow_q}, 9'h001);
    check("ovload.sum_q", {1'b0, sum_q}, 9'h080);

    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      model(ra, rb, rc, ms, mco, mov, mz);
      run_vec("rand", ra, rb, rc, ms, mco, mov, mz);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
